// File: rtl/led_pkg.sv
// Shared parameters and state type for the LED pattern sequencer.
// Included ahead of every other file in the block.
package led_pkg;

  localparam int PAT_W_DEF = 32;
  localparam int PER_W_DEF = 24;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/led_pattern_seq_bit_timer.sv
// Per-bit hold timer: loadable down-counter.
// tc_o pulses while enabled with the count at zero.
module bit_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o = en_i && (cnt_q == '0);

  // load wins over counting; the count parks at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_seq.sv
// Serial LED pattern player with one active word and a
// one-entry pending slot; bit 0 of each word plays first.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [4:0]       pat_len,
  input  logic [PER_W-1:0] pat_period,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic             repeat_i,
  output logic             led,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [PAT_W-1:0] act_data_q;
  logic [4:0]       act_len_q;
  logic [PER_W-1:0] act_per_q;
  logic [PAT_W-1:0] pend_data_q;
  logic [4:0]       pend_len_q;
  logic [PER_W-1:0] pend_per_q;
  logic             pend_vld_q;
  logic [4:0]       idx_q;
  logic             led_q;
  logic             done_q;

  logic             accept;
  logic             tc;
  logic             last;
  logic             tmr_load;
  logic [PER_W-1:0] tmr_val;

  assign pat_ready = !pend_vld_q;
  assign accept    = pat_valid && pat_ready;
  assign last      = tc && (idx_q == act_len_q);

  assign led  = led_q;
  assign done = done_q;
  assign busy = (state_q == PLAY);

  // reload the bit timer on word start and every bit boundary
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = act_per_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = pat_period;
        end
      end
      PLAY: begin
        if (tc) begin
          tmr_load = 1'b1;
          if (last && pend_vld_q)
            tmr_val = pend_per_q;
          else if (last && accept)
            tmr_val = pat_period;
        end
      end
    endcase
  end

  bit_timer #(
    .W(PER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .en_i      (busy),
    .tc_o      (tc)
  );

  // sequencer FSM with registered led/done
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      act_data_q  <= '0;
      act_len_q   <= '0;
      act_per_q   <= '0;
      pend_data_q <= '0;
      pend_len_q  <= '0;
      pend_per_q  <= '0;
      pend_vld_q  <= 1'b0;
      idx_q       <= '0;
      led_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      led_q  <= (state_q == PLAY) ? act_data_q[idx_q] : 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            act_data_q <= pat_data;
            act_len_q  <= pat_len;
            act_per_q  <= pat_period;
            idx_q      <= '0;
            state_q    <= PLAY;
          end
        end
        PLAY: begin
          if (accept && !last) begin
            pend_data_q <= pat_data;
            pend_len_q  <= pat_len;
            pend_per_q  <= pat_period;
            pend_vld_q  <= 1'b1;
          end
          if (tc && !last) begin
            idx_q <= idx_q + 5'd1;
          end
          if (last) begin
            done_q <= 1'b1;
            idx_q  <= '0;
            unique case (1'b1)
              pend_vld_q: begin
                act_data_q <= pend_data_q;
                act_len_q  <= pend_len_q;
                act_per_q  <= pend_per_q;
                pend_vld_q <= 1'b0;
              end
              accept: begin
                act_data_q <= pat_data;
                act_len_q  <= pat_len;
                act_per_q  <= pat_period;
              end
              default: begin
                if (!repeat_i)
                  state_q <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq.
// Inputs change and outputs are sampled on the falling edge.
module tb_led_pattern_seq;

  logic        clk;
  logic        reset;
  logic [31:0] pat_data;
  logic [4:0]  pat_len;
  logic [23:0] pat_period;
  logic        pat_valid;
  logic        pat_ready;
  logic        repeat_i;
  logic        led;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_seq #(
    .PAT_W(32),
    .PER_W(24)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pat_data  (pat_data),
    .pat_len   (pat_len),
    .pat_period(pat_period),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .repeat_i  (repeat_i),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d,
                      input logic [4:0]  l,
                      input logic [23:0] p);
    pat_data   = d;
    pat_len    = l;
    pat_period = p;
    pat_valid  = 1'b1;
  endtask

  logic [7:0] exp_a;

  initial begin
    reset      = 1'b1;
    repeat_i   = 1'b0;
    send(32'hFFFF_FFFF, 5'd3, 24'd0);
    exp_a      = 8'h33;

    // reset with pat_valid high must not start a pattern
    step();
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(pat_ready), 32'd1);
    reset     = 1'b0;
    pat_valid = 1'b0;
    step();
    chk("rst_idle_busy", 32'(busy), 32'd0);

    // data=5 len=3 period=1
    send(32'h5, 5'd3, 24'd1);
    step();
    pat_valid = 1'b0;
    chk("p1_busy", 32'(busy), 32'd1);
    chk("p1_led0", 32'(led), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("p1_led%0d", i), 32'(led), 32'(exp_a[i]));
      chk($sformatf("p1_done%0d", i), 32'(done), 32'(i == 7));
    end
    chk("p1_busy_end", 32'(busy), 32'd0);
    step();
    chk("p1_idle_led", 32'(led), 32'd0);
    chk("p1_idle_done", 32'(done), 32'd0);

    // period=0 len=31 alternating bits
    send(32'hAAAA_AAAA, 5'd31, 24'd0);
    step();
    pat_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      step();
      chk($sformatf("p2_led%0d", k), 32'(led), 32'(k & 1));
      chk($sformatf("p2_done%0d", k), 32'(done), 32'(k == 31));
    end
    step();
    chk("p2_idle_led", 32'(led), 32'd0);
    chk("p2_idle_busy", 32'(busy), 32'd0);

    // second word queued in pending during play
    send(32'h5, 5'd3, 24'd1);
    step();
    chk("p3_ready_a", 32'(pat_ready), 32'd1);
    send(32'h3, 5'd1, 24'd0);
    step();
    chk("p3_ready_drop", 32'(pat_ready), 32'd0);
    chk("p3_led0", 32'(led), 32'd1);
    pat_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("p3_led%0d", i), 32'(led), 32'(exp_a[i]));
      chk($sformatf("p3_done%0d", i), 32'(done), 32'(i == 7));
      chk($sformatf("p3_busy%0d", i), 32'(busy), 32'd1);
    end
    chk("p3_ready_back", 32'(pat_ready), 32'd1);
    step();
    chk("p3_b_led0", 32'(led), 32'd1);
    chk("p3_b_done0", 32'(done), 32'd0);
    chk("p3_b_busy", 32'(busy), 32'd1);
    step();
    chk("p3_b_led1", 32'(led), 32'd1);
    chk("p3_b_done1", 32'(done), 32'd1);
    chk("p3_b_idle", 32'(busy), 32'd0);
    step();
    chk("p3_end_led", 32'(led), 32'd0);
    chk("p3_end_done", 32'(done), 32'd0);

    // accept exactly on final terminal count: bypass
    send(32'h1, 5'd0, 24'd2);
    step();
    pat_valid = 1'b0;
    step();
    chk("p4_led_a1", 32'(led), 32'd1);
    step();
    chk("p4_led_a2", 32'(led), 32'd1);
    send(32'h1, 5'd1, 24'd0);
    step();
    pat_valid = 1'b0;
    chk("p4_led_a3", 32'(led), 32'd1);
    chk("p4_done_a", 32'(done), 32'd1);
    chk("p4_busy_a", 32'(busy), 32'd1);
    step();
    chk("p4_b_led0", 32'(led), 32'd1);
    chk("p4_b_done0", 32'(done), 32'd0);
    step();
    chk("p4_b_led1", 32'(led), 32'd0);
    chk("p4_b_done1", 32'(done), 32'd1);
    chk("p4_b_idle", 32'(busy), 32'd0);
    step();
    chk("p4_end_led", 32'(led), 32'd0);

    // repeat: 1,1,1,0,0,0 looping
    repeat_i = 1'b1;
    send(32'h1, 5'd1, 24'd2);
    step();
    pat_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("p5_led%0d", i), 32'(led), 32'((i % 6) < 3));
      chk($sformatf("p5_done%0d", i), 32'(done), 32'((i % 6) == 5));
      chk($sformatf("p5_busy%0d", i), 32'(busy), 32'd1);
    end
    step();
    chk("p5_led12", 32'(led), 32'd1);
    repeat_i = 1'b0;
    for (int i = 13; i < 18; i++) begin
      step();
      chk($sformatf("p5_led%0d", i), 32'(led), 32'((i % 6) < 3));
      chk($sformatf("p5_done%0d", i), 32'(done), 32'(i == 17));
    end
    chk("p5_stop_busy", 32'(busy), 32'd0);
    step();
    chk("p5_stop_led", 32'(led), 32'd0);

    // reset mid-pattern with a pending word
    send(32'hFF, 5'd7, 24'd3);
    step();
    send(32'hF, 5'd3, 24'd0);
    step();
    pat_valid = 1'b0;
    chk("p6_ready_full", 32'(pat_ready), 32'd0);
    chk("p6_led_a", 32'(led), 32'd1);
    step();
    chk("p6_led_b", 32'(led), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("p6_rst_led", 32'(led), 32'd0);
    chk("p6_rst_busy", 32'(busy), 32'd0);
    chk("p6_rst_ready", 32'(pat_ready), 32'd1);
    chk("p6_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("p6_post_busy%0d", i), 32'(busy), 32'd0);
      chk($sformatf("p6_post_done%0d", i), 32'(done), 32'd0);
      chk($sformatf("p6_post_led%0d", i), 32'(led), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
LED_PATTERN_SEQ -- requirements
Module: led_pattern_seq

Interface
REQ-001 SHALL have parameter PAT_W, 32, pattern word width in bits.
REQ-002 SHALL have parameter PER_W, 24, width of bit-period field.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port pat_data  in  PAT_W  pattern bits, bit 0 played first.
REQ-006 SHALL have port pat_len  in  5  number of bits to play minus 1 (0..31).
REQ-007 SHALL have port pat_period  in  PER_W  clk cycles per bit minus 1.
REQ-008 SHALL have port pat_valid  in  1  upstream word valid.
REQ-009 SHALL have port pat_ready  out  1  block can accept a word.
REQ-010 SHALL have port repeat  in  1  loop active pattern when no word pending.
REQ-011 SHALL have port led  out  1  registered LED drive.
REQ-012 SHALL have port busy  out  1  high while in PLAY.
REQ-013 SHALL have port done  out  1  one-cycle pulse at end of each pattern pass.

Function
REQ-014 SHALL transfer a word on a clk edge where pat_valid and pat_ready are both high; data, len, period are captured together.
REQ-015 SHALL hold one active word plus a one-entry pending register; pat_ready = pending register empty.
REQ-016 SHALL implement states IDLE and PLAY; IDLE: led=0, busy=0.
REQ-017 SHALL in IDLE, on accept, load the word directly into active, go to PLAY next cycle with bit index 0 and timer 0.
REQ-018 SHALL in PLAY, on accept, store the word in the pending register.
REQ-019 SHALL drive led = active_data[bit_index], registered, one cycle after the index/data update.
REQ-020 SHALL hold each bit for exactly pat_period+1 cycles; pat_period=0 gives one cycle per bit.
REQ-021 SHALL advance bit_index on timer terminal count; index never exceeds captured len.
REQ-022 SHALL on terminal count of bit index len pulse done for exactly one cycle.
REQ-023 SHALL at pattern end: if pending full, load pending into active with no gap cycle and clear pending; else if repeat=1, restart active at index 0; else go to IDLE.
REQ-024 SHALL, when an accept coincides with pattern end and pending is empty, load the accepted word directly into active with no gap (bypass).
REQ-025 SHALL sample repeat only at pattern end; changes mid-pattern have no effect on the current pass.
REQ-026 SHALL ignore pat_data/len/period changes while pat_valid is low or pat_ready is low.

Reset
REQ-027 SHALL on reset=1 at a clk edge force state IDLE, led=0, busy=0, done=0, pat_ready=1, index and timer 0, pending empty.
REQ-028 SHALL discard active and pending words when reset asserts mid-pattern; no done pulse is generated.
REQ-029 SHALL ignore pat_valid during the reset cycle.

Structure
REQ-030 SHALL place PAT_W, PER_W defaults and the IDLE/PLAY state type in shared package led_pkg.
REQ-031 SHALL instantiate one sub-module, bit_timer: PER_W-bit down-counter with load, enable and terminal-count pulse.
REQ-032 SHALL register all outputs; no combinational input-to-output path except pat_ready from pending state.

Verification
REQ-033 SHALL cover: reset, accept data=32'h5, len=3, period=1 -> led 1,1,0,0,1,1,0,0 then done pulse, return to IDLE, led=0.
REQ-034 SHALL cover: period=0, len=31, data=32'hAAAAAAAA -> led toggles every cycle, done after 32 bit-cycles.
REQ-035 SHALL cover: second word sent during PLAY -> pat_ready drops after accept, second pattern starts with no idle cycle after first done.
REQ-036 SHALL cover: repeat=1, data=32'h1, len=1, period=2 -> led pattern 1,1,1,0,0,0 loops with done every 6 cycles.
REQ-037 SHALL cover: reset asserted mid-pattern -> next cycle led=0, busy=0, pat_ready=1, no done pulse.
REQ-038 SHALL cover: accept coinciding with final terminal count, pending empty -> new word's bit 0 appears with no gap.
